// File: rtl/game_loop_sequencer_pkg.sv
// Shared definitions for the game-loop frame scheduler: FSM state encoding
// and width helpers for the stage timer and the task/layer indices.
package game_loop_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_UPD_REQ   = 3'd1,
    ST_UPD_WAIT  = 3'd2,
    ST_DRAW_SEL  = 3'd3,
    ST_DRAW_REQ  = 3'd4,
    ST_DRAW_WAIT = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam int TIMER_MIN_WIDTH   = 12;
  localparam int FRAME_COUNT_WIDTH = 16;

  // Stage timer is never narrower than 12 bits so TIMEOUT can be raised freely.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < TIMER_MIN_WIDTH) ? TIMER_MIN_WIDTH : w;
  endfunction

  function automatic int index_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/game_loop_sequencer_tick_gen.sv
// Free-running periodic tick: counts 0..P-1 and flags the last count.
// Shared by the frame scheduler and the score/blink timers.
module tick_gen
  import game_loop_sequencer_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int TICK_HZ    = 10
) (
  input  logic i_clock,
  input  logic i_reset_n,
  output logic o_tick
);

  localparam int PERIOD = CLOCK_FREQ / TICK_HZ;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == CW'(PERIOD - 1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = w_last;

endmodule

// File: rtl/game_loop_sequencer.sv
// Frame scheduler: per tick runs the update tasks in order, then draws the
// enabled layers back-to-front through the DrawMif handshake.
//
//   state        | meaning
//   ST_IDLE      | waiting for a tick (or held pending tick) with pause low
//   ST_UPD_REQ   | update_req[i] pulse, stage timer cleared
//   ST_UPD_WAIT  | waiting for update_done[i] or timeout
//   ST_DRAW_SEL  | skip disabled layers, load origin of layer j
//   ST_DRAW_REQ  | draw high until DrawMif drops ready (accept)
//   ST_DRAW_WAIT | waiting for DrawMif ready to return
//   ST_DONE      | frame_done pulse, frame counter advance
module game_loop_sequencer
  import game_loop_sequencer_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int TICK_HZ    = 10,
  parameter int NUM_UPDATE = 4,
  parameter int NUM_LAYER  = 4,
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 9,
  parameter int ROM_WIDTH  = 4,
  parameter int TIMEOUT    = 4095
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic                           i_pause,
  output logic [NUM_UPDATE-1:0]          o_update_req,
  input  logic [NUM_UPDATE-1:0]          i_update_done,
  input  logic [NUM_LAYER-1:0]           i_layer_en,
  input  logic [NUM_LAYER*X_WIDTH-1:0]   i_layer_x,
  input  logic [NUM_LAYER*Y_WIDTH-1:0]   i_layer_y,
  input  logic [NUM_LAYER*ROM_WIDTH-1:0] i_layer_rom,
  output logic                           o_draw,
  output logic [X_WIDTH-1:0]             o_draw_x,
  output logic [Y_WIDTH-1:0]             o_draw_y,
  output logic [ROM_WIDTH-1:0]           o_draw_rom,
  input  logic                           i_draw_ready,
  output logic                           o_busy,
  output logic                           o_frame_done,
  output logic [FRAME_COUNT_WIDTH-1:0]   o_frame_count,
  output logic                           o_overrun,
  output logic                           o_timeout_err
);

  localparam int TW = timer_width(TIMEOUT);
  localparam int IW = index_width(NUM_UPDATE);
  localparam int JW = index_width(NUM_LAYER);

  state_t                         r_state;
  logic [IW-1:0]                  r_i;
  logic [JW-1:0]                  r_j;
  logic [TW-1:0]                  r_timer;
  logic [NUM_LAYER-1:0]           r_layer_en;
  logic                           r_pending;
  logic [NUM_UPDATE-1:0]          r_update_req;
  logic                           r_draw;
  logic [X_WIDTH-1:0]             r_draw_x;
  logic [Y_WIDTH-1:0]             r_draw_y;
  logic [ROM_WIDTH-1:0]           r_draw_rom;
  logic                           r_busy;
  logic                           r_frame_done;
  logic [FRAME_COUNT_WIDTH-1:0]   r_frame_count;
  logic                           r_overrun;
  logic                           r_timeout_err;

  logic                           w_tick;
  logic                           w_timer_exp;
  logic                           w_upd_done;
  logic [NUM_UPDATE-1:0]          w_req_next;
  logic                           w_sel_en;
  logic [X_WIDTH-1:0]             w_sel_x;
  logic [Y_WIDTH-1:0]             w_sel_y;
  logic [ROM_WIDTH-1:0]           w_sel_rom;

  tick_gen #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .TICK_HZ    (TICK_HZ)
  ) u_tick_gen (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .o_tick    (w_tick)
  );

  assign w_timer_exp = (r_timer == TW'(TIMEOUT));

  // Index muxes written as compare loops so index widths never exceed the vectors.
  always_comb begin
    w_upd_done = 1'b0;
    w_req_next = '0;
    for (int k = 0; k < NUM_UPDATE; k++) begin
      if (r_i == IW'(k)) w_upd_done = i_update_done[k];
      w_req_next[k] = (k > 0) && (r_i == IW'(k - 1));
    end
  end

  always_comb begin
    w_sel_en  = 1'b0;
    w_sel_x   = '0;
    w_sel_y   = '0;
    w_sel_rom = '0;
    for (int k = 0; k < NUM_LAYER; k++) begin
      if (r_j == JW'(k)) begin
        w_sel_en  = r_layer_en[k];
        w_sel_x   = i_layer_x[k*X_WIDTH +: X_WIDTH];
        w_sel_y   = i_layer_y[k*Y_WIDTH +: Y_WIDTH];
        w_sel_rom = i_layer_rom[k*ROM_WIDTH +: ROM_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_timer       <= '0;
      r_layer_en    <= '0;
      r_pending     <= 1'b0;
      r_update_req  <= '0;
      r_draw        <= 1'b0;
      r_draw_x      <= '0;
      r_draw_y      <= '0;
      r_draw_rom    <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_update_req <= '0;
      r_frame_done <= 1'b0;
      if (!w_timer_exp) r_timer <= r_timer + 1'b1;

      // Only one tick is remembered while a frame runs; extras are lost.
      if (w_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if ((w_tick || r_pending) && !i_pause) begin
            r_busy       <= 1'b1;
            r_layer_en   <= i_layer_en;
            r_i          <= '0;
            r_pending    <= 1'b0;
            r_update_req <= NUM_UPDATE'(1);
            r_timer      <= '0;
            r_state      <= ST_UPD_REQ;
          end else if (i_pause) begin
            r_pending <= 1'b0;
          end
        end

        ST_UPD_REQ: begin
          r_timer <= '0;
          r_state <= ST_UPD_WAIT;
        end

        ST_UPD_WAIT: begin
          if (w_upd_done || w_timer_exp) begin
            if (w_timer_exp && !w_upd_done) r_timeout_err <= 1'b1;
            r_timer <= '0;
            if (r_i == IW'(NUM_UPDATE - 1)) begin
              r_j     <= '0;
              r_state <= ST_DRAW_SEL;
            end else begin
              r_i          <= r_i + 1'b1;
              r_update_req <= w_req_next;
              r_state      <= ST_UPD_REQ;
            end
          end
        end

        ST_DRAW_SEL: begin
          r_timer <= '0;
          if (r_j == JW'(NUM_LAYER)) begin
            r_frame_done <= 1'b1;
            r_state      <= ST_DONE;
          end else if (w_sel_en) begin
            r_draw_x   <= w_sel_x;
            r_draw_y   <= w_sel_y;
            r_draw_rom <= w_sel_rom;
            r_draw     <= 1'b1;
            r_state    <= ST_DRAW_REQ;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end

        ST_DRAW_REQ: begin
          if (!i_draw_ready) begin
            r_draw  <= 1'b0;
            r_timer <= '0;
            r_state <= ST_DRAW_WAIT;
          end else if (w_timer_exp) begin
            r_draw        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_j           <= r_j + 1'b1;
            r_timer       <= '0;
            r_state       <= ST_DRAW_SEL;
          end
        end

        ST_DRAW_WAIT: begin
          if (i_draw_ready || w_timer_exp) begin
            if (!i_draw_ready) r_timeout_err <= 1'b1;
            r_j     <= r_j + 1'b1;
            r_timer <= '0;
            r_state <= ST_DRAW_SEL;
          end
        end

        ST_DONE: begin
          r_busy        <= 1'b0;
          r_frame_count <= r_frame_count + 1'b1;
          r_timer       <= '0;
          r_state       <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_update_req  = r_update_req;
  assign o_draw        = r_draw;
  assign o_draw_x      = r_draw_x;
  assign o_draw_y      = r_draw_y;
  assign o_draw_rom    = r_draw_rom;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_frame_count = r_frame_count;
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_game_loop_sequencer.sv
// Directed bench for game_loop_sequencer with P=100, two update tasks,
// three layers and TIMEOUT=50; expected cycles are hand-derived.
module tb_game_loop_sequencer;

  localparam int NU = 2;
  localparam int NL = 3;
  localparam int XW = 8;
  localparam int YW = 9;
  localparam int RW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pause = 1'b0;
  logic [NU-1:0]   update_req;
  logic [NU-1:0]   update_done;
  logic [NL-1:0]   layer_en;
  logic [NL*XW-1:0] layer_x;
  logic [NL*YW-1:0] layer_y;
  logic [NL*RW-1:0] layer_rom;
  logic            draw;
  logic [XW-1:0]   draw_x;
  logic [YW-1:0]   draw_y;
  logic [RW-1:0]   draw_rom;
  logic            draw_ready;
  logic            busy;
  logic            frame_done;
  logic [15:0]     frame_count;
  logic            overrun;
  logic            timeout_err;

  game_loop_sequencer #(
    .CLOCK_FREQ (1000),
    .TICK_HZ    (10),
    .NUM_UPDATE (NU),
    .NUM_LAYER  (NL),
    .X_WIDTH    (XW),
    .Y_WIDTH    (YW),
    .ROM_WIDTH  (RW),
    .TIMEOUT    (50)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_pause       (pause),
    .o_update_req  (update_req),
    .i_update_done (update_done),
    .i_layer_en    (layer_en),
    .i_layer_x     (layer_x),
    .i_layer_y     (layer_y),
    .i_layer_rom   (layer_rom),
    .o_draw        (draw),
    .o_draw_x      (draw_x),
    .o_draw_y      (draw_y),
    .o_draw_rom    (draw_rom),
    .i_draw_ready  (draw_ready),
    .o_busy        (busy),
    .o_frame_done  (frame_done),
    .o_frame_count (frame_count),
    .o_overrun     (overrun),
    .o_timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - base);
    end
  endtask

  // Cycle k is the k-th clock period after reset release; observed at its falling edge.
  task automatic at_cycle(input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  // Update tasks answer with a one-cycle done pulse 5 cycles after their request.
  logic [NU-1:0] hang = '0;
  initial begin : upd_model
    int cnt [NU];
    for (int k = 0; k < NU; k++) cnt[k] = 0;
    update_done = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NU; k++) begin
        if (update_req[k]) begin
          cnt[k] = 5;
          update_done[k] = 1'b0;
        end else if (cnt[k] > 0) begin
          cnt[k]--;
          update_done[k] = (cnt[k] == 0) && !hang[k];
        end else begin
          update_done[k] = 1'b0;
        end
      end
    end
  end

  // DrawMif: drops ready 2 cycles after draw, raises it low_len cycles later.
  int low_len = 10;
  initial begin : draw_model
    int phase;
    int dcnt;
    phase = 0;
    dcnt = 0;
    draw_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (phase)
        0: if (draw) begin phase = 1; dcnt = 0; end
        1: begin
          dcnt++;
          if (dcnt == 2) begin draw_ready = 1'b0; phase = 2; dcnt = 0; end
        end
        default: begin
          dcnt++;
          if (dcnt == low_len) begin draw_ready = 1'b1; phase = 0; end
        end
      endcase
    end
  end

  int   draw_rises = 0;
  int   l1_cycles = 0;
  int   req_pulses = 0;
  logic prev_draw = 1'b0;
  always @(negedge clk) begin
    prev_draw <= draw;
    if (draw && !prev_draw) draw_rises <= draw_rises + 1;
    if (draw_x == 8'h22) l1_cycles <= l1_cycles + 1;
    if (|update_req) req_pulses <= req_pulses + 1;
  end

  localparam logic [20:0] L0 = {8'h11, 9'h101, 4'h1};
  localparam logic [20:0] L2 = {8'h33, 9'h1C3, 4'h3};

  int snap_rises;
  int snap_l1;
  int snap_req;

  initial begin
    layer_x   = {8'h33, 8'h22, 8'h11};
    layer_y   = {9'h1C3, 9'h0A2, 9'h101};
    layer_rom = {4'h3, 4'h2, 4'h1};
    layer_en  = 3'b111;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_draw", {31'd0, draw}, 0);
    check_val("rst_busy", {31'd0, busy}, 0);
    check_val("rst_req", {30'd0, update_req}, 0);
    check_val("rst_count", {16'd0, frame_count}, 0);
    check_val("rst_flags", {29'd0, frame_done, overrun, timeout_err}, 0);
    rst_n = 1'b1;
    base = cyc;

    // first tick at cycle 99 -> request visible at 100
    at_cycle(99);  check_val("no_req_before_tick", {30'd0, update_req}, 0);
    at_cycle(100); check_val("req0", {30'd0, update_req}, 32'h1);
                   check_val("busy_set", {31'd0, busy}, 1);
    at_cycle(101); check_val("req0_one_cycle", {30'd0, update_req}, 0);
    at_cycle(106); check_val("req1", {30'd0, update_req}, 32'h2);
    at_cycle(113); check_val("draw0_req", {31'd0, draw}, 1);
                   check_val("draw0_org", {11'd0, draw_x, draw_y, draw_rom}, {11'd0, L0});
    at_cycle(116); check_val("draw0_accept", {31'd0, draw}, 0);
    at_cycle(127); check_val("draw1_org", {10'd0, draw, draw_x, draw_y, draw_rom},
                             {10'd0, 1'b1, 8'h22, 9'h0A2, 4'h2});
    at_cycle(141); check_val("draw2_org", {10'd0, draw, draw_x, draw_y, draw_rom}, {10'd0, 1'b1, L2});
    at_cycle(155); check_val("frame1_done", {31'd0, frame_done}, 1);
    at_cycle(156); check_val("frame1_count", {15'd0, frame_count, busy}, {15'd0, 16'd1, 1'b0});

    // layer mask 101, with a mid-frame enable change that must be ignored
    at_cycle(160); layer_en = 3'b101; snap_rises = draw_rises; snap_l1 = l1_cycles;
    at_cycle(205); layer_en = 3'b111;
    at_cycle(213); check_val("mask_draw_a", {10'd0, draw, draw_x, draw_y, draw_rom}, {10'd0, 1'b1, L0});
    at_cycle(228); check_val("mask_draw_b", {10'd0, draw, draw_x, draw_y, draw_rom}, {10'd0, 1'b1, L2});
    at_cycle(242); check_val("frame2_done", {31'd0, frame_done}, 1);
    at_cycle(245); check_val("mask_draw_count", draw_rises - snap_rises, 2);
                   check_val("mask_no_layer1", l1_cycles - snap_l1, 0);
                   check_val("frame2_count", {16'd0, frame_count}, 2);

    // update task 1 never answers
    at_cycle(250); layer_en = 3'b001; hang = 2'b10;
    at_cycle(357); check_val("timeout_not_yet", {31'd0, timeout_err}, 0);
    at_cycle(358); check_val("timeout_set", {31'd0, timeout_err}, 1);
    at_cycle(359); check_val("draw_after_timeout", {31'd0, draw}, 1);
    at_cycle(375); check_val("frame3_done", {31'd0, frame_done}, 1);
    at_cycle(380); check_val("frame3_count", {16'd0, frame_count}, 3);
                   check_val("no_overrun_yet", {31'd0, overrun}, 0);

    // long frame spanning ticks at 499 and 599
    hang = 2'b11; low_len = 150; layer_en = 3'b111;
    at_cycle(499); check_val("overrun_before", {31'd0, overrun}, 0);
    at_cycle(500); check_val("overrun_set", {31'd0, overrun}, 1);
    at_cycle(659); check_val("frame4_done", {31'd0, frame_done}, 1);
    hang = 2'b00; low_len = 10; layer_en = 3'b001;
    at_cycle(660); check_val("frame4_idle", {15'd0, frame_count, busy}, {15'd0, 16'd4, 1'b0});
    at_cycle(661); check_val("pending_start", {30'd0, update_req}, 32'h1);
    at_cycle(690); check_val("frame5_done", {31'd0, frame_done}, 1);
    at_cycle(695); check_val("no_extra_frame", {31'd0, busy}, 0);
                   check_val("frame5_count", {16'd0, frame_count}, 5);
    at_cycle(700); check_val("tick_frame6", {30'd0, update_req}, 32'h1);

    // asynchronous reset while drawing
    at_cycle(714); check_val("draw_before_rst", {31'd0, draw}, 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_async_draw_busy", {30'd0, draw, busy}, 0);
    check_val("rst_async_count", {16'd0, frame_count}, 0);
    check_val("rst_async_flags", {30'd0, overrun, timeout_err}, 0);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    snap_req = req_pulses;

    // paused across ticks at 99 and 199
    at_cycle(250); check_val("pause_no_req", req_pulses - snap_req, 0);
                   check_val("pause_count", {15'd0, frame_count, busy}, 0);
    pause = 1'b0;
    at_cycle(300); check_val("unpause_req", {30'd0, update_req}, 32'h1);
    at_cycle(329); check_val("frame_after_pause", {31'd0, frame_done}, 1);
    at_cycle(330); check_val("count_after_pause", {16'd0, frame_count}, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
